axis_pkt_len_meter: RTL and testbench

Passive AXI-Stream packet-length monitor and the parametrised successor of the fixed 64-bit byte counter. It snoops a tvalid/tready/tlast/tkeep bus and, for each packet, reports the byte length with a one-cycle valid strobe. It also checks tkeep legality, saturates on overflow, and keeps running packet and error statistics. It sits beside the UDP TX/RX datapath to feed header length fields and debug counters, and never drives the bus.

---
 rtl/axis_pkt_len_meter.sv | 190 +++++++++++++++++++
 tb/tb_axis_pkt_len_meter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_len_meter.sv
// axis_pkt_len_meter
// Passive AXI-Stream packet-length monitor. It watches tvalid/tready/tlast/tkeep
// and reports each packet's byte length with a one-cycle strobe. It also flags
// illegal tkeep patterns and length overflow (the length saturates), and keeps
// wrapping packet/error counters. It never drives the bus.
module axis_pkt_len_meter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  axis_tvalid,
    input  logic                  axis_tready,
    input  logic [DATA_WIDTH-1:0] axis_tdata,
    input  logic                  axis_tlast,
    input  logic [KEEP_WIDTH-1:0] axis_tkeep,
    input  logic                  stat_clear,
    output logic                  len_valid,
    output logic [LEN_WIDTH-1:0]  packet_len_bytes,
    output logic                  len_err,
    output logic                  in_packet,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int POP_W = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    // Number of enabled bytes in a beat.
    function automatic logic [POP_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] v);
        logic [POP_W-1:0] c;
        c = {POP_W{1'b0}};
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    // True when the set bits form a run starting at bit 0 (includes all-zero).
    // Adding one to such a value clears every set bit, so the AND is zero.
    function automatic logic keep_contiguous(input logic [KEEP_WIDTH-1:0] v);
        logic [KEEP_WIDTH-1:0] v_inc;
        v_inc = v + KEEP_WIDTH'(1);
        return ((v & v_inc) == {KEEP_WIDTH{1'b0}});
    endfunction

    // The data bus is not inspected; it is folded here only so it is consumed.
    logic unused_tdata_s;
    assign unused_tdata_s = ^axis_tdata;

    // Registered state
    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  acc_q, acc_d;
    logic                  kerr_q, kerr_d;
    logic                  ovf_q, ovf_d;
    logic                  len_valid_q, len_valid_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  len_err_q, len_err_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    // Beat qualification and arithmetic
    logic                  beat_s;
    logic                  last_beat_s;
    logic                  mid_beat_s;
    logic [POP_W-1:0]      pop_s;
    logic [LEN_WIDTH:0]    sum_s;
    logic                  sum_ovf_s;
    logic [LEN_WIDTH-1:0]  sat_s;
    logic                  keep_full_s;
    logic                  keep_last_ok_s;
    logic                  pkt_err_s;

    assign beat_s         = axis_tvalid & axis_tready;
    assign last_beat_s    = beat_s & axis_tlast;
    assign mid_beat_s     = beat_s & ~axis_tlast;
    assign pop_s          = popcount(axis_tkeep);
    // One extra bit so the carry out of the length field is visible.
    assign sum_s          = {1'b0, acc_q} + (LEN_WIDTH + 1)'(pop_s);
    assign sum_ovf_s      = sum_s[LEN_WIDTH];
    assign sat_s          = sum_ovf_s ? {LEN_WIDTH{1'b1}} : sum_s[LEN_WIDTH-1:0];
    assign keep_full_s    = &axis_tkeep;
    assign keep_last_ok_s = keep_contiguous(axis_tkeep);
    // Error status of the packet closing on this beat, including the beat itself.
    assign pkt_err_s      = kerr_q | ovf_q | ~keep_last_ok_s | sum_ovf_s;

    // Packet framing FSM: IN_PKT between the first and the last accepted beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mid_beat_s) begin
                    state_d = ST_IN_PKT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IN_PKT: begin
                if (last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IN_PKT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Length accumulation, error flags and the length/strobe output registers.
    always_comb begin
        acc_d       = acc_q;
        kerr_d      = kerr_q;
        ovf_d       = ovf_q;
        len_valid_d = 1'b0;
        len_d       = len_q;
        len_err_d   = len_err_q;
        if (last_beat_s) begin
            len_d       = sat_s;
            len_err_d   = pkt_err_s;
            len_valid_d = 1'b1;
            acc_d       = {LEN_WIDTH{1'b0}};
            kerr_d      = 1'b0;
            ovf_d       = 1'b0;
        end else if (mid_beat_s) begin
            // Bytes are still counted on a violating beat; only the flag records it.
            acc_d  = sat_s;
            kerr_d = kerr_q | ~keep_full_s;
            ovf_d  = ovf_q | sum_ovf_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Statistics counters; a clear takes priority over a coincident increment.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (stat_clear) begin
            pkt_cnt_d = {CNT_WIDTH{1'b0}};
            err_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (last_beat_s) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            err_cnt_d = err_cnt_q + CNT_WIDTH'(pkt_err_s);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // State register with synchronous active-low reset; a partial packet is dropped.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_q     <= ST_IDLE;
            acc_q       <= {LEN_WIDTH{1'b0}};
            kerr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            len_valid_q <= 1'b0;
            len_q       <= {LEN_WIDTH{1'b0}};
            len_err_q   <= 1'b0;
            pkt_cnt_q   <= {CNT_WIDTH{1'b0}};
            err_cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            kerr_q      <= kerr_d;
            ovf_q       <= ovf_d;
            len_valid_q <= len_valid_d;
            len_q       <= len_d;
            len_err_q   <= len_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign len_valid        = len_valid_q;
    assign packet_len_bytes = len_q;
    assign len_err          = len_err_q;
    assign in_packet        = (state_q == ST_IN_PKT);
    assign pkt_count        = pkt_cnt_q;
    assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_axis_pkt_len_meter.sv
// Bench for axis_pkt_len_meter. Two instances share one stimulus bus: the default
// 16-bit length build and an 8-bit length build used for saturation. A behavioural
// model turns each driven beat into expected strobes held in per-instance queues.
module tb_axis_pkt_len_meter;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          tvalid, tready, tlast, clr;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;

    logic          lv, lerr, inp;
    logic [15:0]   len;
    logic [31:0]   pkt, errc;
    logic          lv8, lerr8, inp8;
    logic [7:0]    len8;
    logic [31:0]   pkt8, errc8;

    always #5 clk = ~clk;

    axis_pkt_len_meter #(.DATA_WIDTH(DW), .LEN_WIDTH(16), .CNT_WIDTH(32)) u_dut (
        .axis_aclk(clk), .axis_aresetn(rstn), .axis_tvalid(tvalid), .axis_tready(tready),
        .axis_tdata(tdata), .axis_tlast(tlast), .axis_tkeep(tkeep), .stat_clear(clr),
        .len_valid(lv), .packet_len_bytes(len), .len_err(lerr), .in_packet(inp),
        .pkt_count(pkt), .err_count(errc)
    );

    axis_pkt_len_meter #(.DATA_WIDTH(DW), .LEN_WIDTH(8), .CNT_WIDTH(32)) u_dut8 (
        .axis_aclk(clk), .axis_aresetn(rstn), .axis_tvalid(tvalid), .axis_tready(tready),
        .axis_tdata(tdata), .axis_tlast(tlast), .axis_tkeep(tkeep), .stat_clear(clr),
        .len_valid(lv8), .packet_len_bytes(len8), .len_err(lerr8), .in_packet(inp8),
        .pkt_count(pkt8), .err_count(errc8)
    );

    typedef struct {
        int          cyc;
        int          len;
        bit          err;
        logic [31:0] pkt;
        logic [31:0] errc;
    } exp_t;

    exp_t        q16[$];
    exp_t        q8[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    // Model state
    int          m_acc16, m_acc8;
    bit          m_kerr, m_ovf16, m_ovf8, m_inpkt;
    logic [31:0] m_pkt, m_errc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc16 = 0; m_acc8 = 0;
        m_kerr = 1'b0; m_ovf16 = 1'b0; m_ovf8 = 1'b0; m_inpkt = 1'b0;
        m_pkt = 32'd0; m_errc = 32'd0;
    endtask

    // Drive one cycle of the bus and advance the model to the post-edge state.
    task automatic drive(input bit v, input bit r, input bit l, input logic [7:0] k, input bit c);
        int         p, s16, s8;
        bit         viol, e16, e8;
        logic [8:0] mask;
        exp_t       x16, x8;
        @(negedge clk);
        tvalid = v; tready = r; tlast = l; tkeep = k; clr = c;
        tdata  = {$urandom, $urandom};
        e16 = 1'b0; e8 = 1'b0; s16 = 0; s8 = 0;
        if (v && r) begin
            p   = $countones(k);
            s16 = m_acc16 + p;
            s8  = m_acc8 + p;
            if (!l) begin
                m_kerr  |= (k != 8'hFF);
                m_ovf16 |= (s16 > 65535);
                m_ovf8  |= (s8 > 255);
                m_acc16  = (s16 > 65535) ? 65535 : s16;
                m_acc8   = (s8 > 255) ? 255 : s8;
                m_inpkt  = 1'b1;
            end else begin
                mask = 9'((1 << p) - 1);
                viol = ({1'b0, k} != mask);
                e16  = m_kerr | m_ovf16 | viol | (s16 > 65535);
                e8   = m_kerr | m_ovf8 | viol | (s8 > 255);
                m_pkt  = m_pkt + 32'd1;
                m_errc = m_errc + 32'(e16);
            end
        end
        if (c) begin
            m_pkt = 32'd0; m_errc = 32'd0;
        end
        if (v && r && l) begin
            x16 = '{cyc + 1, (s16 > 65535) ? 65535 : s16, e16, m_pkt, m_errc};
            x8  = '{cyc + 1, (s8 > 255) ? 255 : s8, e8, 32'd0, 32'd0};
            q16.push_back(x16);
            q8.push_back(x8);
            m_acc16 = 0; m_acc8 = 0;
            m_kerr = 1'b0; m_ovf16 = 1'b0; m_ovf8 = 1'b0; m_inpkt = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tkeep = 8'h00; clr = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Output monitor: framing every cycle, strobes against the scoreboards.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            chk("in_packet", 64'(inp), 64'(m_inpkt));
            chk("in_packet_w8", 64'(inp8), 64'(m_inpkt));
            if (lv) begin
                if (q16.size() == 0) begin
                    chk("spurious_len_valid", 64'(lv), 64'd0);
                end else begin
                    e = q16.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    chk("packet_len_bytes", 64'(len), 64'(e.len));
                    chk("len_err", 64'(lerr), 64'(e.err));
                    chk("pkt_count", 64'(pkt), 64'(e.pkt));
                    chk("err_count", 64'(errc), 64'(e.errc));
                end
            end else if (q16.size() != 0 && q16[0].cyc <= cyc) begin
                chk("missed_len_valid", 64'(lv), 64'd1);
                void'(q16.pop_front());
            end
            if (lv8) begin
                if (q8.size() == 0) begin
                    chk("spurious_len_valid_w8", 64'(lv8), 64'd0);
                end else begin
                    e = q8.pop_front();
                    chk("strobe_cycle_w8", 64'(cyc), 64'(e.cyc));
                    chk("packet_len_bytes_w8", 64'(len8), 64'(e.len));
                    chk("len_err_w8", 64'(lerr8), 64'(e.err));
                end
            end else if (q8.size() != 0 && q8[0].cyc <= cyc) begin
                chk("missed_len_valid_w8", 64'(lv8), 64'd1);
                void'(q8.pop_front());
            end
        end
    end

    initial begin
        rstn = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tkeep = 8'h00; clr = 1'b0;
        tdata = '0;
        model_reset();
        mon_en = 1'b1;

        // Reset state
        do_reset(20);
        chk("rst_len_valid", 64'(lv), 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        chk("rst_len_err", 64'(lerr), 64'd0);
        chk("rst_in_packet", 64'(inp), 64'd0);
        chk("rst_pkt_count", 64'(pkt), 64'd0);
        chk("rst_err_count", 64'(errc), 64'd0);

        // Two multi-beat packets: 20*8+4 and 40*8+4
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h0F, 1'b0);
        idle(2);
        chk("len_164", 64'(len), 64'd164);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h0F, 1'b0);
        idle(3);
        chk("len_324", 64'(len), 64'd324);
        chk("pkt_after_two", 64'(pkt), 64'd2);
        chk("len8_sat_324", 64'(len8), 64'd255);

        // Clear alone, then back-to-back single-beat packets 1, 8, 0 bytes
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        idle(3);
        chk("pkt_singles", 64'(pkt), 64'd3);
        chk("err_singles", 64'(errc), 64'd0);
        chk("len_single_zero", 64'(len), 64'd0);

        // tready toggling: only accepted beats count, including the last
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, (i == 7), 8'hFF, 1'b0);
            drive(1'b1, 1'b1, (i == 7), 8'hFF, 1'b0);
        end
        idle(3);
        chk("len_tready_toggle", 64'(len), 64'd64);

        // Non-contiguous keep on a middle beat and the last beat: 8+7+2
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h7F, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h05, 1'b0);
        idle(2);
        chk("len_keep_viol", 64'(len), 64'd17);
        chk("err_after_viol", 64'(errc), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
        idle(2);
        chk("len_clean", 64'(len), 64'd9);
        chk("err_after_clean", 64'(errc), 64'd1);

        // Saturation on the 8-bit build, then recovery on a short packet
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        idle(2);
        chk("len8_sat", 64'(len8), 64'd255);
        chk("len16_328", 64'(len), 64'd328);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        idle(2);
        chk("len8_after_sat", 64'(len8), 64'd16);

        // Clear on the last-beat cycle: counters end at zero, length still reported
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h3F, 1'b1);
        idle(2);
        chk("pkt_clear_on_last", 64'(pkt), 64'd0);
        chk("err_clear_on_last", 64'(errc), 64'd0);
        chk("len_clear_on_last", 64'(len), 64'd14);

        // Reset mid-packet: nothing reported, next packet starts from zero
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        do_reset(3);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h07, 1'b0);
        idle(3);
        chk("len_after_reset", 64'(len), 64'd11);
        chk("pkt_after_reset", 64'(pkt), 64'd1);

        idle(2);
        chk("scoreboard_drained", 64'(q16.size() + q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
